// File: rtl/tlk2711_link_test_ctrl.sv
// TLK2711 receive link test sequencer: soft-resets the validator, waits for a
// clean lock window, runs a timed check and reports error statistics and a verdict.
module tlk2711_link_test_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 1000000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [31:0]          i_test_cycles,
  input  logic [CNT_WIDTH-1:0] i_err_threshold,
  input  logic [15:0]          i_err_mask,
  input  logic                 i_check_error,
  input  logic [3:0]           i_error_status,
  output logic                 o_soft_rst,
  output logic                 o_check_ena,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_lock_fail,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic [15:0]          o_err_codes,
  output logic [3:0]           o_first_err_code,
  output logic [31:0]          o_first_err_cycle,
  output logic [2:0]           o_state
);

  localparam int unsigned RW = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES)       : 1;
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_LOCK  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [31:0]          cfg_last;
  logic [CNT_WIDTH-1:0] cfg_thr;
  logic [15:0]          cfg_mask;

  logic [RW-1:0] rst_cnt;
  logic [LW-1:0] lock_cnt, lock_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [31:0]   run_cnt;

  logic valid_err, start_ok, busy_st, lock_hit, tmo_hit, run_last, run_err;
  logic [CNT_WIDTH-1:0] err_cnt_nxt;

  logic soft_rst_d, check_ena_d, busy_d, done_d, pass_d, lock_fail_d;

  assign valid_err = i_check_error & ~cfg_mask[i_error_status];
  assign busy_st   = (state == ST_RESET) || (state == ST_LOCK) || (state == ST_RUN);
  assign start_ok  = ((state == ST_IDLE) || (state == ST_DONE)) && i_start && !i_abort;
  assign lock_nxt  = valid_err ? '0 : lock_cnt + LW'(1);
  assign tmo_nxt   = tmo_cnt + TW'(1);
  assign lock_hit  = (lock_nxt == LW'(LOCK_CYCLES));
  assign tmo_hit   = (tmo_nxt == TW'(LOCK_TIMEOUT));
  assign run_last  = (run_cnt == cfg_last);
  assign run_err   = (state == ST_RUN) && valid_err && !i_abort;

  assign err_cnt_nxt = (run_err && (o_err_cnt != '1)) ? o_err_cnt + CNT_WIDTH'(1) : o_err_cnt;
  assign o_state     = state;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; abort beats every other transition, lock beats timeout
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) next_state = ST_RESET;
      end
      ST_RESET: begin
        if (i_abort)                                  next_state = ST_IDLE;
        else if (rst_cnt == RW'(RST_CYCLES - 1))      next_state = ST_LOCK;
      end
      ST_LOCK: begin
        if (i_abort)       next_state = ST_IDLE;
        else if (lock_hit) next_state = ST_RUN;
        else if (tmo_hit)  next_state = ST_DONE;
      end
      ST_RUN: begin
        if (i_abort)       next_state = ST_IDLE;
        else if (run_last) next_state = ST_DONE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the flops below line up with state
  always_comb begin
    soft_rst_d  = (next_state == ST_RESET);
    check_ena_d = (next_state == ST_LOCK) || (next_state == ST_RUN);
    busy_d      = (next_state == ST_RESET) || (next_state == ST_LOCK) || (next_state == ST_RUN);
    done_d      = (next_state == ST_DONE);
    lock_fail_d = o_lock_fail;
    pass_d      = o_pass;
    if (start_ok) begin
      lock_fail_d = 1'b0;
    end else if ((state == ST_LOCK) && (next_state == ST_DONE)) begin
      lock_fail_d = 1'b1;
    end
    // Verdict is formed on DONE entry using the count including the final cycle
    if (next_state != ST_DONE) begin
      pass_d = 1'b0;
    end else if (state != ST_DONE) begin
      pass_d = (err_cnt_nxt <= cfg_thr) && (state != ST_LOCK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_soft_rst  <= 1'b0;
      o_check_ena <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_lock_fail <= 1'b0;
    end else begin
      o_soft_rst  <= soft_rst_d;
      o_check_ena <= check_ena_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
      o_pass      <= pass_d;
      o_lock_fail <= lock_fail_d;
    end
  end

  // Configuration, phase counters and error statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_last          <= '0;
      cfg_thr           <= '0;
      cfg_mask          <= '0;
      rst_cnt           <= '0;
      lock_cnt          <= '0;
      tmo_cnt           <= '0;
      run_cnt           <= '0;
      o_err_cnt         <= '0;
      o_err_codes       <= '0;
      o_first_err_code  <= '0;
      o_first_err_cycle <= '1;
    end else if (start_ok) begin
      cfg_last          <= (i_test_cycles == '0) ? '0 : i_test_cycles - 32'd1;
      cfg_thr           <= i_err_threshold;
      cfg_mask          <= i_err_mask;
      rst_cnt           <= '0;
      lock_cnt          <= '0;
      tmo_cnt           <= '0;
      run_cnt           <= '0;
      o_err_cnt         <= '0;
      o_err_codes       <= '0;
      o_first_err_code  <= '0;
      o_first_err_cycle <= '1;
    end else if (busy_st && !i_abort) begin
      if (state == ST_RESET) rst_cnt <= rst_cnt + RW'(1);
      if (state == ST_LOCK) begin
        lock_cnt <= lock_nxt;
        tmo_cnt  <= tmo_nxt;
      end
      if (state == ST_RUN) begin
        run_cnt   <= run_cnt + 32'd1;
        o_err_cnt <= err_cnt_nxt;
        if (run_err) begin
          o_err_codes[i_error_status] <= 1'b1;
          // Count saturates rather than wraps, so zero means no error seen yet
          if (o_err_cnt == '0) begin
            o_first_err_code  <= i_error_status;
            o_first_err_cycle <= run_cnt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tlk2711_link_test_ctrl.sv
// Directed bench for tlk2711_link_test_ctrl with shortened phase lengths
// (RST=4, LOCK=32, TIMEOUT=200, 8-bit error counter).
module tb_tlk2711_link_test_ctrl;

  localparam int unsigned RC = 4;
  localparam int unsigned LC = 32;
  localparam int unsigned LT = 200;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [31:0]   i_test_cycles = '0;
  logic [CW-1:0] i_err_threshold = '0;
  logic [15:0]   i_err_mask = '0;
  logic          i_check_error = 1'b0;
  logic [3:0]    i_error_status = '0;
  logic          o_soft_rst, o_check_ena, o_busy, o_done, o_pass, o_lock_fail;
  logic [CW-1:0] o_err_cnt;
  logic [15:0]   o_err_codes;
  logic [3:0]    o_first_err_code;
  logic [31:0]   o_first_err_cycle;
  logic [2:0]    o_state;

  int n_tests = 0;
  int n_fail  = 0;
  int err_at[$];
  int rl, ll, nl;

  tlk2711_link_test_ctrl #(
    .RST_CYCLES(RC), .LOCK_CYCLES(LC), .LOCK_TIMEOUT(LT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_test_cycles(i_test_cycles), .i_err_threshold(i_err_threshold),
    .i_err_mask(i_err_mask), .i_check_error(i_check_error),
    .i_error_status(i_error_status), .o_soft_rst(o_soft_rst),
    .o_check_ena(o_check_ena), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_lock_fail(o_lock_fail), .o_err_cnt(o_err_cnt),
    .o_err_codes(o_err_codes), .o_first_err_code(o_first_err_code),
    .o_first_err_cycle(o_first_err_cycle), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Live config is scrambled right after the start pulse to prove latching
  task automatic start_test(input logic [31:0] n, input logic [CW-1:0] thr, input logic [15:0] mask);
    i_test_cycles = n; i_err_threshold = thr; i_err_mask = mask;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_test_cycles = 32'd7; i_err_threshold = '0; i_err_mask = 16'hFFFF;
  endtask

  // Count cycles spent in state st, injecting errors on listed phase cycles
  task automatic phase(input logic [2:0] st, input bit cont, input logic [3:0] code, output int len);
    len = 0;
    while (o_state == st && len < 5000) begin
      i_check_error = cont;
      foreach (err_at[i]) if (err_at[i] == len) i_check_error = 1'b1;
      i_error_status = code;
      tick();
      len++;
    end
    i_check_error = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("rst_state", o_state, 0);
    check("rst_first_cycle", o_first_err_cycle, 32'hFFFF_FFFF);
    check("rst_first_code", o_first_err_code, 0);
    check("rst_flags", {o_soft_rst, o_check_ena, o_busy, o_done, o_pass, o_lock_fail}, 0);
    check("rst_cnt_codes", {o_err_cnt, o_err_codes}, 0);
    rst_n = 1'b1;
    tick();

    // Clean link
    start_test(50, 0, 0);
    check("t1_soft_rst_rise", o_soft_rst, 1);
    check("t1_busy", o_busy, 1);
    err_at.delete();
    phase(3'd1, 0, 0, rl);
    check("t1_rst_len", rl, RC);
    check("t1_check_ena", {o_soft_rst, o_check_ena}, 2'b01);
    phase(3'd2, 0, 0, ll);
    check("t1_lock_len", ll, LC);
    phase(3'd3, 0, 0, nl);
    check("t1_run_len", nl, 50);
    check("t1_done_state", o_state, 4);
    check("t1_flags", {o_check_ena, o_busy, o_done, o_pass, o_lock_fail}, 5'b00110);
    check("t1_cnt", o_err_cnt, 0);
    check("t1_codes", o_err_codes, 0);
    check("t1_first_cycle", o_first_err_cycle, 32'hFFFF_FFFF);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    check("t1_abort_in_done", {o_state, o_done, o_pass}, {3'd4, 2'b11});

    // Three code-8 errors including the final run cycle, threshold 2
    start_test(50, 2, 0);
    check("t2_restart", o_state, 1);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 0, 0, ll);
    err_at = '{10, 20, 49};
    phase(3'd3, 0, 4'd8, nl);
    check("t2_run_len", nl, 50);
    check("t2_cnt", o_err_cnt, 3);
    check("t2_codes", o_err_codes, 16'h0100);
    check("t2_first_code", o_first_err_code, 8);
    check("t2_first_cycle", o_first_err_cycle, 10);
    check("t2_pass", {o_done, o_pass}, 2'b10);

    // Count equal to threshold passes; error on cycle 0
    start_test(50, 2, 0);
    err_at.delete();
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 0, 0, ll);
    err_at = '{0, 49};
    phase(3'd3, 0, 4'd5, nl);
    check("t2b_cnt", o_err_cnt, 2);
    check("t2b_first_cycle", o_first_err_cycle, 0);
    check("t2b_codes", o_err_codes, 16'h0020);
    check("t2b_pass", o_pass, 1);

    // Continuous masked code-1 errors
    err_at.delete();
    start_test(40, 0, 16'h0002);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 1, 4'd1, ll);
    check("t3_lock_len", ll, LC);
    phase(3'd3, 1, 4'd1, nl);
    check("t3_run_len", nl, 40);
    check("t3_cnt", o_err_cnt, 0);
    check("t3_pass", o_pass, 1);

    // Same stimulus unmasked: lock timeout
    start_test(40, 0, 0);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 1, 4'd1, ll);
    check("t3b_lock_len", ll, LT);
    check("t3b_state", o_state, 4);
    check("t3b_flags", {o_done, o_pass, o_lock_fail}, 3'b101);
    check("t3b_cnt", o_err_cnt, 0);

    // Periodic LOCK errors then clean: exit LC cycles after the last error
    start_test(20, 0, 0);
    phase(3'd1, 0, 0, rl);
    err_at = '{5, 15, 25, 35};
    phase(3'd2, 0, 4'd2, ll);
    check("t4_lock_len", ll, 35 + 1 + LC);
    err_at.delete();
    phase(3'd3, 0, 0, nl);
    check("t4_cnt", {o_err_cnt, o_err_codes}, 0);
    check("t4_pass", o_pass, 1);

    // Lock and timeout on the same cycle: lock wins
    start_test(20, 0, 0);
    phase(3'd1, 0, 0, rl);
    err_at.delete();
    for (int i = 7; i <= 167; i += 20) err_at.push_back(i);
    phase(3'd2, 0, 4'd2, ll);
    check("t4b_lock_len", ll, LT);
    check("t4b_state", o_state, 3);
    err_at.delete();
    phase(3'd3, 0, 0, nl);
    check("t4b_flags", {o_pass, o_lock_fail}, 2'b10);

    // Saturation with threshold at max
    start_test(300, 8'hFF, 0);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 0, 0, ll);
    phase(3'd3, 1, 4'd3, nl);
    check("t5_run_len", nl, 300);
    check("t5_cnt_sat", o_err_cnt, 8'hFF);
    check("t5_codes", o_err_codes, 16'h0008);
    check("t5_first", {o_first_err_code, o_first_err_cycle}, {4'd3, 32'd0});
    check("t5_pass", o_pass, 1);

    // Zero test length runs one cycle
    start_test(0, 0, 0);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 0, 0, ll);
    err_at = '{0};
    phase(3'd3, 0, 4'd15, nl);
    check("t6_run_len", nl, 1);
    check("t6_cnt", o_err_cnt, 1);
    check("t6_codes", o_err_codes, 16'h8000);
    check("t6_pass", o_pass, 0);

    // Start ignored while busy, then abort at RUN cycle 10
    err_at.delete();
    start_test(100, 0, 0);
    phase(3'd1, 0, 0, rl);
    phase(3'd2, 0, 0, ll);
    for (int k = 0; k < 10; k++) begin
      i_check_error  = (k == 3);
      i_error_status = 4'd6;
      i_start        = (k == 5);
      tick();
    end
    i_check_error = 1'b0; i_start = 1'b0;
    check("t7_start_ignored", o_state, 3);
    i_abort = 1'b1; tick(); i_abort = 1'b0;
    check("t7_abort_state", o_state, 0);
    check("t7_abort_flags", {o_soft_rst, o_check_ena, o_busy, o_done, o_pass}, 0);
    check("t7_held", {o_err_cnt, o_first_err_cycle}, {8'd1, 32'd3});

    // Start together with abort in IDLE
    i_test_cycles = 10; i_start = 1'b1; i_abort = 1'b1;
    tick();
    i_start = 1'b0; i_abort = 1'b0;
    check("t8_start_abort", {o_state, o_soft_rst, o_busy}, 5'b00000);

    // Asynchronous reset mid-LOCK
    start_test(50, 0, 0);
    phase(3'd1, 0, 0, rl);
    repeat (5) tick();
    check("t9_in_lock", o_state, 2);
    #3 rst_n = 1'b0;
    #1;
    check("t9_async_state", o_state, 0);
    check("t9_async_flags", {o_soft_rst, o_check_ena, o_busy, o_done, o_pass, o_lock_fail}, 0);
    check("t9_async_first", o_first_err_cycle, 32'hFFFF_FFFF);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
